// File: rtl/frame_copy_scheduler.sv
// frame_copy_scheduler
//   Per-frame sequencer for the rectangle DMA copy into the GPU. On vsync it
//   asks the CPU to halt at an instruction boundary. Once the CPU acknowledges,
//   it hands the data-memory read port to the rect copy controller and pulses
//   copy_start. It then holds the port for COPY_CYCLES cycles and hands it
//   back to the CPU.
// Ports:
//   clk, reset (async, active low)
//   vsync        one-cycle frame-start pulse
//   cpu_halted   CPU halt acknowledge (level)
//   overrun_clr  clears the sticky overrun flag
//   cpu_halt_req halt request to the CPU
//   mem_sel      read-port mux select (0 = CPU, 1 = copy controller)
//   copy_start   one-cycle start pulse to the copy controller
//   copy_busy    sequencer not idle
//   copy_done    one-cycle pulse when a copy finishes
//   frame_count  completed copies (wraps)
//   skip_count   frames dropped on halt timeout (saturates)
//   overrun      sticky: vsync arrived while busy
module frame_copy_scheduler #(
  parameter int COPY_CYCLES  = 9984,
  parameter int HALT_TIMEOUT = 255,
  parameter int CNT_WIDTH    = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        cpu_halted,
  input  logic        overrun_clr,
  output logic        cpu_halt_req,
  output logic        mem_sel,
  output logic        copy_start,
  output logic        copy_busy,
  output logic        copy_done,
  output logic [15:0] frame_count,
  output logic [7:0]  skip_count,
  output logic        overrun
);

  localparam logic [CNT_WIDTH-1:0] COPY_LAST = CNT_WIDTH'(COPY_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HALT_LAST = CNT_WIDTH'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HALT_REQ, START, COPY, RELEASE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout;

  logic        halt_q, halt_d;
  logic        mem_q, mem_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] frame_q, frame_d;
  logic [7:0]  skip_q, skip_d;
  logic        ovr_q, ovr_d;

  // State and output registers. Outputs are decoded from the next state so
  // every output is a flop that lines up with the state it describes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      mem_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      frame_q <= '0;
      skip_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      mem_q   <= mem_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      skip_q  <= skip_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vsync) begin
          state_d = HALT_REQ;
          cnt_d   = '0;
        end
      end
      HALT_REQ: begin
        // A halt ack in the timeout cycle still starts the copy.
        if (cpu_halted) begin
          state_d = START;
        end else if (cnt_q == HALT_LAST) begin
          state_d = IDLE;
          timeout = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        state_d = COPY;
        cnt_d   = '0;
      end
      COPY: begin
        // cpu_halted is deliberately not looked at here; once the copy has
        // started it runs to completion.
        if (cnt_q == COPY_LAST) state_d = RELEASE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. mem_sel only rises in START while halt_req is already high,
  // and drops together with halt_req, so the CPU never runs across a switch.
  always_comb begin
    halt_d  = (state_d == HALT_REQ) || (state_d == START) || (state_d == COPY);
    mem_d   = (state_d == START) || (state_d == COPY);
    start_d = (state_d == START);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == RELEASE);
    frame_d = (state_d == RELEASE) ? frame_q + 16'd1 : frame_q;
    skip_d  = (timeout && skip_q != 8'hFF) ? skip_q + 8'd1 : skip_q;
    // set beats clear
    if (vsync && state_q != IDLE) ovr_d = 1'b1;
    else if (overrun_clr)         ovr_d = 1'b0;
    else                          ovr_d = ovr_q;
  end

  assign cpu_halt_req = halt_q;
  assign mem_sel      = mem_q;
  assign copy_start   = start_q;
  assign copy_busy    = busy_q;
  assign copy_done    = done_q;
  assign frame_count  = frame_q;
  assign skip_count   = skip_q;
  assign overrun      = ovr_q;

endmodule
